mips_cpu: RTL and testbench

//  Single-cycle 32-bit MIPS-subset processor core; executes one instruction per clk.

---
 rtl/mips_cpu.sv | 131 +++++++++++++
 tb/tb_mips_cpu.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu.sv
// Single-cycle 32-bit MIPS-subset core: combinational fetch/decode/execute, state commit on posedge clk.
// Optional define CPU_SHIFTV_EN enables the variable shifts sllv/srlv/srav.
module mips_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_read_data,
  output logic        wren,
  output logic [31:0] mem_write_data
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B
  } op_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04,
    FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08, FN_ADD  = 6'h20,
    FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24,
    FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_e;

  logic [31:0] regs [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] rs_val, rt_val, simm, zimm, pc4, br_target, j_target;
  logic [31:0] alu, wr_data, next_pc;
  logic [4:0]  wr_addr;
  logic        wr_en, store;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];
  assign shamt = inst[10:6];
  assign funct = inst[5:0];

  assign rs_val    = (rs == 5'd0) ? '0 : regs[rs];
  assign rt_val    = (rt == 5'd0) ? '0 : regs[rt];
  assign simm      = {{16{inst[15]}}, inst[15:0]};
  assign zimm      = {16'h0000, inst[15:0]};
  assign pc4       = pc + 32'd4;
  assign br_target = pc4 + {simm[29:0], 2'b00};
  assign j_target  = {pc4[31:28], inst[25:0], 2'b00};

  always_comb begin
    alu     = '0;
    wr_en   = 1'b0;
    wr_addr = rt;
    next_pc = pc4;
    store   = 1'b0;
    case (op)
      OP_RTYPE: begin
        wr_en   = 1'b1;
        wr_addr = rd;
        case (funct)
          FN_ADD, FN_ADDU: alu = rs_val + rt_val;
          FN_SUB, FN_SUBU: alu = rs_val - rt_val;
          FN_AND:          alu = rs_val & rt_val;
          FN_OR:           alu = rs_val | rt_val;
          FN_XOR:          alu = rs_val ^ rt_val;
          FN_NOR:          alu = ~(rs_val | rt_val);
          FN_SLT:          alu = {31'd0, $signed(rs_val) < $signed(rt_val)};
          FN_SLTU:         alu = {31'd0, rs_val < rt_val};
          FN_SLL:          alu = rt_val << shamt;
          FN_SRL:          alu = rt_val >> shamt;
          FN_SRA:          alu = $signed(rt_val) >>> shamt;
`ifdef CPU_SHIFTV_EN
          FN_SLLV:         alu = rt_val << rs_val[4:0];
          FN_SRLV:         alu = rt_val >> rs_val[4:0];
          FN_SRAV:         alu = $signed(rt_val) >>> rs_val[4:0];
`endif
          FN_JR: begin
            wr_en   = 1'b0;
            next_pc = rs_val;
          end
          default:         wr_en = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin alu = rs_val + simm; wr_en = 1'b1; end
      OP_SLTI:  begin alu = {31'd0, $signed(rs_val) < $signed(simm)}; wr_en = 1'b1; end
      OP_SLTIU: begin alu = {31'd0, rs_val < simm}; wr_en = 1'b1; end
      OP_ANDI:  begin alu = rs_val & zimm; wr_en = 1'b1; end
      OP_ORI:   begin alu = rs_val | zimm; wr_en = 1'b1; end
      OP_XORI:  begin alu = rs_val ^ zimm; wr_en = 1'b1; end
      OP_LUI:   begin alu = {inst[15:0], 16'h0000}; wr_en = 1'b1; end
      OP_LW:    begin alu = rs_val + simm; wr_en = 1'b1; end
      OP_SW:    begin alu = rs_val + simm; store = 1'b1; end
      OP_BEQ:   if (rs_val == rt_val) next_pc = br_target;
      OP_BNE:   if (rs_val != rt_val) next_pc = br_target;
      OP_J:     next_pc = j_target;
      OP_JAL: begin
        next_pc = j_target;
        wr_en   = 1'b1;
        wr_addr = 5'd31;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_data = alu;
    if (op == OP_LW)       wr_data = mem_read_data;
    else if (op == OP_JAL) wr_data = pc4;
  end

  assign mem_addr       = alu;
  assign mem_write_data = rt_val;
  assign wren           = store & rst;

  // Low pc bits are dropped so an unaligned jr target still yields a word-aligned fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= {next_pc[31:2], 2'b00};
      if (wr_en && (wr_addr != 5'd0)) regs[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mips_cpu.sv
// Self-checking bench for mips_cpu: directed scenarios plus randomized instruction stream
// checked against an instruction-level architectural model.
module tb_mips_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] mem_addr;
  logic [31:0] mem_read_data;
  logic        wren;
  logic [31:0] mem_write_data;

  int passed = 0;
  int total  = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_pc;

  mips_cpu #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .inst(inst), .pc(pc), .mem_addr(mem_addr),
    .mem_read_data(mem_read_data), .wren(wren), .mem_write_data(mem_write_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [4:0] sh);
    return {6'h00, s, t, d, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                        input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] tg);
    return {op, tg};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0000_0000;
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
  endtask

  // Architectural effect of one instruction on the register file and pc.
  task automatic model_step(input logic [31:0] i, input logic [31:0] ld);
    logic [5:0]  op, fn;
    logic [4:0]  s, t, d, sh, dest;
    logic [31:0] a, b, se, res, npc;
    logic        we;
    op = i[31:26]; s = i[25:21]; t = i[20:16]; d = i[15:11]; sh = i[10:6]; fn = i[5:0];
    a = m_gpr[s]; b = m_gpr[t];
    se = {{16{i[15]}}, i[15:0]};
    npc = m_pc + 32'd4;
    res = '0; we = 1'b1; dest = t;
    case (op)
      6'h00: begin
        dest = d;
        case (fn)
          6'h20, 6'h21: res = a + b;
          6'h22, 6'h23: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h27: res = ~(a | b);
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: res = (a < b) ? 32'd1 : 32'd0;
          6'h00: res = b << sh;
          6'h02: res = b >> sh;
          6'h03: res = $signed(b) >>> sh;
`ifdef CPU_SHIFTV_EN
          6'h04: res = b << a[4:0];
          6'h06: res = b >> a[4:0];
          6'h07: res = $signed(b) >>> a[4:0];
`endif
          6'h08: begin we = 1'b0; npc = a; end
          default: we = 1'b0;
        endcase
      end
      6'h08, 6'h09: res = a + se;
      6'h0A: res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
      6'h0B: res = (a < se) ? 32'd1 : 32'd0;
      6'h0C: res = a & {16'h0, i[15:0]};
      6'h0D: res = a | {16'h0, i[15:0]};
      6'h0E: res = a ^ {16'h0, i[15:0]};
      6'h0F: res = {i[15:0], 16'h0};
      6'h23: res = ld;
      6'h2B: we = 1'b0;
      6'h04: begin we = 1'b0; if (a == b) npc = npc + (se << 2); end
      6'h05: begin we = 1'b0; if (a != b) npc = npc + (se << 2); end
      6'h02: begin we = 1'b0; npc = {npc[31:28], i[25:0], 2'b00}; end
      6'h03: begin res = npc; dest = 5'd31; npc = {npc[31:28], i[25:0], 2'b00}; end
      default: we = 1'b0;
    endcase
    if (we && dest != 5'd0) m_gpr[dest] = res;
    m_pc = {npc[31:2], 2'b00};
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] ld, input logic r);
    @(negedge clk);
    inst = i; mem_read_data = ld; rst = r;
    #1;
  endtask

  task automatic retire();
    if (!rst) model_reset();
    else model_step(inst, mem_read_data);
    @(posedge clk);
  endtask

  task automatic test_reset();
    issue(i_ins(6'h2B, 5'd0, 5'd1, 16'h0), 32'h0, 1'b0);
    total++; if (wren !== 1'b0) $display("FAIL rst_wren0 got %b exp 0", wren); else passed++;
    retire();
    issue(i_ins(6'h2B, 5'd0, 5'd1, 16'h0), 32'h0, 1'b0);
    total++; if (pc !== 32'h0) $display("FAIL rst_pc got %h exp 00000000", pc); else passed++;
    retire();
    issue(32'h0, 32'h0, 1'b1);
    total++; if (pc !== 32'h0) $display("FAIL rst_pc_rel got %h exp 00000000", pc); else passed++;
    total++; if (wren !== 1'b0) $display("FAIL rst_wren1 got %b exp 0", wren); else passed++;
    retire();
    issue(32'h0, 32'h0, 1'b1);
    total++; if (pc !== 32'h4) $display("FAIL rst_pc_next got %h exp 00000004", pc); else passed++;
    retire();
    for (int r = 1; r < 32; r++) begin
      issue(i_ins(6'h2B, 5'd0, 5'(r), 16'h0), 32'h0, 1'b1);
      total++;
      if (mem_write_data !== 32'h0 || wren !== 1'b1)
        $display("FAIL rst_gpr%0d got %h/%b exp 00000000/1", r, mem_write_data, wren);
      else passed++;
      retire();
    end
  endtask

  task automatic test_alu();
    logic [31:0] exp_v [6];
    logic [4:0]  regs_v [6];
    issue(i_ins(6'h09, 5'd0, 5'd1, 16'd5), 0, 1); retire();
    issue(i_ins(6'h09, 5'd0, 5'd2, 16'hFFFD), 0, 1); retire();
    issue(r_ins(6'h21, 5'd1, 5'd2, 5'd3, 5'd0), 0, 1); retire();
    issue(r_ins(6'h2A, 5'd2, 5'd1, 5'd4, 5'd0), 0, 1); retire();
    issue(r_ins(6'h2B, 5'd2, 5'd1, 5'd5, 5'd0), 0, 1); retire();
    issue(r_ins(6'h03, 5'd0, 5'd2, 5'd8, 5'd1), 0, 1); retire();
    issue(r_ins(6'h23, 5'd1, 5'd2, 5'd9, 5'd0), 0, 1); retire();
    issue(i_ins(6'h0B, 5'd1, 5'd11, 16'hFFFF), 0, 1); retire();
    regs_v = '{5'd3, 5'd4, 5'd5, 5'd8, 5'd9, 5'd11};
    exp_v  = '{32'd2, 32'd1, 32'd0, 32'hFFFF_FFFE, 32'd8, 32'd1};
    for (int k = 0; k < 6; k++) begin
      issue(i_ins(6'h2B, 5'd0, regs_v[k], 16'h0), 0, 1);
      total++;
      if (mem_write_data !== exp_v[k])
        $display("FAIL alu_r%0d got %h exp %h", regs_v[k], mem_write_data, exp_v[k]);
      else passed++;
      retire();
    end
  endtask

  task automatic test_mem();
    issue(i_ins(6'h0F, 5'd0, 5'd6, 16'h1234), 0, 1); retire();
    issue(i_ins(6'h0D, 5'd6, 5'd6, 16'h5678), 0, 1); retire();
    issue(i_ins(6'h2B, 5'd0, 5'd6, 16'd8), 0, 1);
    total++; if (wren !== 1'b1) $display("FAIL sw_wren got %b exp 1", wren); else passed++;
    total++; if (mem_addr !== 32'd8) $display("FAIL sw_addr got %h exp 00000008", mem_addr); else passed++;
    total++; if (mem_write_data !== 32'h1234_5678) $display("FAIL sw_data got %h exp 12345678", mem_write_data); else passed++;
    retire();
    issue(i_ins(6'h23, 5'd0, 5'd7, 16'd8), 32'hDEAD_BEEF, 1);
    total++; if (mem_addr !== 32'd8 || wren !== 1'b0) $display("FAIL lw_addr got %h/%b exp 00000008/0", mem_addr, wren); else passed++;
    retire();
    issue(i_ins(6'h09, 5'd0, 5'd0, 16'd1), 0, 1); retire();
    issue(i_ins(6'h2B, 5'd0, 5'd7, 16'h0), 0, 1);
    total++; if (mem_write_data !== 32'hDEAD_BEEF) $display("FAIL lw_data got %h exp deadbeef", mem_write_data); else passed++;
    retire();
    issue(i_ins(6'h2B, 5'd0, 5'd0, 16'd4), 0, 1);
    total++; if (mem_write_data !== 32'h0) $display("FAIL r0_zero got %h exp 00000000", mem_write_data); else passed++;
    retire();
    issue(i_ins(6'h2B, 5'd1, 5'd6, 16'hFFFC), 0, 1);
    total++; if (mem_addr !== 32'd1) $display("FAIL sw_negoff got %h exp 00000001", mem_addr); else passed++;
    retire();
  endtask

  task automatic test_branch();
    issue(j_ins(6'h02, 26'h4), 0, 1); retire();
    issue(i_ins(6'h04, 5'd0, 5'd0, 16'hFFFE), 0, 1);
    total++; if (pc !== 32'h10) $display("FAIL j_pc got %h exp 00000010", pc); else passed++;
    retire();
    issue(i_ins(6'h05, 5'd0, 5'd0, 16'd3), 0, 1);
    total++; if (pc !== 32'h0C) $display("FAIL beq_pc got %h exp 0000000c", pc); else passed++;
    retire();
    issue(j_ins(6'h03, 26'h40), 0, 1);
    total++; if (pc !== 32'h10) $display("FAIL bne_pc got %h exp 00000010", pc); else passed++;
    retire();
    issue(i_ins(6'h2B, 5'd0, 5'd31, 16'h0), 0, 1);
    total++; if (pc !== 32'h100) $display("FAIL jal_pc got %h exp 00000100", pc); else passed++;
    total++; if (mem_write_data !== 32'h14) $display("FAIL jal_link got %h exp 00000014", mem_write_data); else passed++;
    retire();
    issue(r_ins(6'h08, 5'd31, 5'd0, 5'd0, 5'd0), 0, 1); retire();
    issue(i_ins(6'h0F, 5'd0, 5'd1, 16'hFFFF), 0, 1);
    total++; if (pc !== 32'h14) $display("FAIL jr_pc got %h exp 00000014", pc); else passed++;
    retire();
    issue(i_ins(6'h0D, 5'd1, 5'd1, 16'hFFFC), 0, 1); retire();
    issue(r_ins(6'h08, 5'd1, 5'd0, 5'd0, 5'd0), 0, 1); retire();
    issue(32'h0, 0, 1);
    total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL jr_far got %h exp fffffffc", pc); else passed++;
    retire();
    issue(32'h0, 0, 1);
    total++; if (pc !== 32'h0) $display("FAIL pc_wrap got %h exp 00000000", pc); else passed++;
    retire();
  endtask

  task automatic test_nop_shiftv();
    logic [31:0] exp_sh;
    for (int n = 0; n < 4; n++) begin
      issue((n % 2 == 0) ? {6'h3F, 26'($urandom)} : {6'h00, 20'($urandom), 6'h3F}, $urandom, 1);
      total++; if (wren !== 1'b0) $display("FAIL nop_wren got %b exp 0", wren); else passed++;
      retire();
    end
    for (int r = 1; r < 32; r++) begin
      issue(i_ins(6'h2B, 5'd0, 5'(r), 16'h0), 0, 1);
      total++;
      if (mem_write_data !== m_gpr[r]) $display("FAIL nop_gpr%0d got %h exp %h", r, mem_write_data, m_gpr[r]);
      else passed++;
      retire();
    end
    issue(i_ins(6'h09, 5'd0, 5'd1, 16'd1), 0, 1); retire();
    issue(i_ins(6'h09, 5'd0, 5'd2, 16'd31), 0, 1); retire();
    issue(i_ins(6'h09, 5'd0, 5'd3, 16'h77), 0, 1); retire();
    issue(r_ins(6'h04, 5'd2, 5'd1, 5'd3, 5'd0), 0, 1); retire();
`ifdef CPU_SHIFTV_EN
    exp_sh = 32'h8000_0000;
`else
    exp_sh = 32'h0000_0077;
`endif
    issue(i_ins(6'h2B, 5'd0, 5'd3, 16'h0), 0, 1);
    total++; if (mem_write_data !== exp_sh) $display("FAIL sllv got %h exp %h", mem_write_data, exp_sh); else passed++;
    total++; if (pc !== m_pc) $display("FAIL sllv_pc got %h exp %h", pc, m_pc); else passed++;
    retire();
  endtask

  task automatic test_random();
    logic [5:0]  rfn [18];
    logic [5:0]  iop [8];
    logic [31:0] ins, ld, ea;
    logic [4:0]  s, t, d;
    rfn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
            6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h3F};
    iop = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    for (int n = 0; n < 800; n++) begin
      s = 5'($urandom_range(0, 7)); t = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
      ld = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2: ins = r_ins(rfn[$urandom_range(0, 17)], s, t, d, 5'($urandom));
        3, 4:    ins = i_ins(iop[$urandom_range(0, 7)], s, t, 16'($urandom));
        5:       ins = i_ins(6'h23, s, t, 16'($urandom));
        6:       ins = i_ins(6'h2B, s, t, 16'($urandom));
        7:       ins = i_ins(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, s,
                             ($urandom_range(0, 1) == 0) ? s : t, 16'($urandom));
        8:       ins = j_ins(($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03, 26'($urandom));
        default: ins = {6'h3F, 26'($urandom)};
      endcase
      issue(ins, ld, 1);
      ea = m_gpr[s] + {{16{ins[15]}}, ins[15:0]};
      total++; if (pc !== m_pc) $display("FAIL rand_pc[%0d] got %h exp %h", n, pc, m_pc); else passed++;
      total++;
      if (wren !== (ins[31:26] == 6'h2B)) $display("FAIL rand_wren[%0d] got %b exp %b", n, wren, ins[31:26] == 6'h2B);
      else passed++;
      if (ins[31:26] == 6'h2B || ins[31:26] == 6'h23) begin
        total++; if (mem_addr !== ea) $display("FAIL rand_addr[%0d] got %h exp %h", n, mem_addr, ea); else passed++;
      end
      if (ins[31:26] == 6'h2B) begin
        total++;
        if (mem_write_data !== m_gpr[t]) $display("FAIL rand_sdata[%0d] got %h exp %h", n, mem_write_data, m_gpr[t]);
        else passed++;
      end
      retire();
    end
    for (int r = 0; r < 32; r++) begin
      issue(i_ins(6'h2B, 5'd0, 5'(r), 16'h0), 0, 1);
      total++;
      if (mem_write_data !== m_gpr[r]) $display("FAIL rand_gpr%0d got %h exp %h", r, mem_write_data, m_gpr[r]);
      else passed++;
      retire();
    end
  endtask

  task automatic test_midrun_reset();
    issue(i_ins(6'h09, 5'd0, 5'd9, 16'd7), 0, 1); retire();
    issue(i_ins(6'h09, 5'd0, 5'd9, 16'd55), 0, 0); retire();
    issue(i_ins(6'h2B, 5'd0, 5'd9, 16'h0), 0, 0);
    total++; if (wren !== 1'b0) $display("FAIL mrst_wren got %b exp 0", wren); else passed++;
    retire();
    issue(i_ins(6'h2B, 5'd0, 5'd9, 16'h0), 0, 1);
    total++; if (pc !== 32'h0) $display("FAIL mrst_pc got %h exp 00000000", pc); else passed++;
    total++; if (mem_write_data !== 32'h0) $display("FAIL mrst_gpr9 got %h exp 00000000", mem_write_data); else passed++;
    retire();
  endtask

  initial begin
    rst = 1'b0; inst = '0; mem_read_data = '0;
    model_reset();
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_nop_shiftv();
    test_random();
    test_midrun_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
